// File: rtl/tinyqv_prefetch_buffer.sv
// Instruction prefetch buffer: circular queue of DEPTH halfwords between the
// flash fetch controller and the TinyQV decoder, with in-window redirect hits.
module tinyqv_prefetch_buffer #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,

    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_fetch_restart,
    output logic              instr_fetch_stall,
    input  logic              instr_fetch_started,
    input  logic              instr_fetch_stopped,
    input  logic [15:0]       instr_data_in,
    input  logic              instr_ready,

    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic [CNT_W-1:0]  avail_len,
    input  logic              consume,
    input  logic [1:0]        consume_len,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              debug_redirect_hit
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [15:0]       r_buf [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_pc;
    logic              r_running;
    logic              r_dbg_hit;

    logic [ADDR_W-1:0] w_offset;
    logic              w_hit;
    logic              w_miss;
    logic              w_full;
    logic              w_write;
    logic              w_overrun;
    logic [CNT_W-1:0]  w_len;
    logic              w_cons_ok;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_running_next;
    logic [PTR_W-1:0]  w_head_p1;

    // Redirect classification: target inside the buffered window is a hit
    assign w_offset  = redirect_addr - r_pc;
    assign w_hit     = redirect && (w_offset < ADDR_W'(r_count));
    assign w_miss    = redirect && !w_hit;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_write   = instr_ready && r_running && !w_full && !w_miss;
    assign w_overrun = instr_ready && r_running && w_full;

    assign w_len     = CNT_W'(consume_len);
    assign w_cons_ok = consume && !redirect && (consume_len != 2'b00) && (w_len <= r_count);

    always_comb begin
        w_count_next = r_count;
        if (rst) begin
            w_count_next = '0;
        end else if (w_miss) begin
            w_count_next = '0;
        end else if (w_hit) begin
            w_count_next = r_count - CNT_W'(w_offset) + CNT_W'(w_write);
        end else begin
            w_count_next = r_count + CNT_W'(w_write) - (w_cons_ok ? w_len : CNT_W'(0));
        end
    end

    // Loss of stream (miss or overrun) dominates the controller handshake
    always_comb begin
        w_running_next = r_running;
        if (w_miss || w_overrun) begin
            w_running_next = 1'b0;
        end else if (instr_fetch_started) begin
            w_running_next = 1'b1;
        end else if (instr_fetch_stopped) begin
            w_running_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_head    <= '0;
            r_wr      <= '0;
            r_count   <= '0;
            r_pc      <= '0;
            r_running <= 1'b0;
            r_dbg_hit <= 1'b0;
        end else begin
            if (w_write) begin
                r_buf[r_wr] <= instr_data_in;
            end
            if (w_miss) begin
                r_head <= '0;
                r_wr   <= '0;
            end else begin
                if (w_hit) begin
                    r_head <= r_head + PTR_W'(w_offset);
                end else if (w_cons_ok) begin
                    r_head <= r_head + PTR_W'(consume_len);
                end
                if (w_write) begin
                    r_wr <= r_wr + PTR_W'(1);
                end
            end
            if (redirect) begin
                r_pc <= redirect_addr;
            end else if (w_cons_ok) begin
                r_pc <= r_pc + ADDR_W'(consume_len);
            end
            r_count   <= w_count_next;
            r_running <= w_running_next;
            r_dbg_hit <= w_hit;
        end
    end

    assign w_head_p1 = r_head + PTR_W'(1);

    assign instr               = {r_buf[w_head_p1], r_buf[r_head]};
    assign avail_len           = r_count;
    assign pc                  = r_pc;
    assign instr_addr          = r_pc + ADDR_W'(r_count);
    assign instr_fetch_restart = rst || (!r_running && !w_miss);
    assign instr_fetch_stall   = (w_count_next == CNT_W'(DEPTH));
    assign debug_redirect_hit  = r_dbg_hit;

endmodule
